// File: rtl/axis_capture_replay.sv
// Captures one AXI-Stream packet (data+keep per beat) into RAM and replays it 1..N times.
// First replay beat is valid 2 cycles after loadInit; 1 beat/cycle; output register holds while TREADY is low.
module axis_capture_replay #(
  parameter int DATA_WIDTH        = 32,
  parameter int STORAGE_IDX_WIDTH = 10,
  parameter int REPLAY_CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         S_AXI_TDATA,
  input  logic [DATA_WIDTH/8-1:0]       S_AXI_TKEEP,
  input  logic                          S_AXI_TVALID,
  output logic                          S_AXI_TREADY,
  input  logic                          S_AXI_TLAST,
  output logic [DATA_WIDTH-1:0]         M_AXI_TDATA,
  output logic [DATA_WIDTH/8-1:0]       M_AXI_TKEEP,
  output logic                          M_AXI_TVALID,
  input  logic                          M_AXI_TREADY,
  output logic                          M_AXI_TLAST,
  input  logic                          storeReset,
  input  logic                          loadReset,
  input  logic                          storeInit,
  input  logic                          loadInit,
  input  logic [REPLAY_CNT_WIDTH-1:0]   replayCount,
  output logic                          finStore,
  output logic                          finLoad,
  output logic                          overflow,
  output logic [STORAGE_IDX_WIDTH:0]    storedBeats
);

  localparam int KW      = DATA_WIDTH / 8;
  localparam int MW      = DATA_WIDTH + KW;
  localparam int PW      = STORAGE_IDX_WIDTH + 1;
  localparam int DEPTH_N = 1 << STORAGE_IDX_WIDTH;

  localparam logic [PW-1:0] DEPTH = {1'b1, {STORAGE_IDX_WIDTH{1'b0}}};
  localparam logic [PW-1:0] ONE   = {{STORAGE_IDX_WIDTH{1'b0}}, 1'b1};
  localparam logic [REPLAY_CNT_WIDTH-1:0] P_ONE = {{(REPLAY_CNT_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STORE = 3'd1;
  localparam logic [2:0] S_DROP  = 3'd2;
  localparam logic [2:0] S_PRIME = 3'd3;
  localparam logic [2:0] S_LOAD  = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [PW-1:0]               stored_q, stored_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [REPLAY_CNT_WIDTH-1:0] passes_q, passes_d;
  logic                        vld_q, vld_d;
  logic                        last_q, last_d;
  logic                        fin_store_q, fin_store_d;
  logic                        fin_load_q, fin_load_d;
  logic                        overflow_q, overflow_d;

  logic [MW-1:0] mem [DEPTH_N];
  logic [MW-1:0] ram_rd_q;
  logic          wr_en;
  logic          rd_en;
  logic [PW-1:0] last_idx;
  logic [PW-1:0] rd_ptr_nxt;

  always_comb begin
    state_d     = state_q;
    stored_d    = stored_q;
    rd_ptr_d    = rd_ptr_q;
    passes_d    = passes_q;
    vld_d       = vld_q;
    last_d      = last_q;
    fin_store_d = fin_store_q;
    fin_load_d  = fin_load_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    last_idx    = stored_q - ONE;
    // Read pointer runs one beat ahead of the output register and wraps per pass.
    rd_ptr_nxt  = (rd_ptr_q == last_idx) ? '0 : rd_ptr_q + ONE;

    case (state_q)
      S_IDLE: begin
        if (storeReset) begin
          stored_d    = '0;
          fin_store_d = 1'b0;
          overflow_d  = 1'b0;
        end else if (loadReset) begin
          rd_ptr_d   = '0;
          fin_load_d = 1'b0;
        end else if (storeInit) begin
          stored_d = '0;
          state_d  = S_STORE;
        end else if (loadInit) begin
          if (stored_q == '0) begin
            fin_load_d = 1'b1;
          end else begin
            passes_d = (replayCount == '0) ? P_ONE : replayCount;
            rd_ptr_d = '0;
            state_d  = S_PRIME;
          end
        end
      end
      S_STORE: begin
        if (S_AXI_TVALID) begin
          wr_en    = 1'b1;
          stored_d = stored_q + ONE;
          if (S_AXI_TLAST) begin
            fin_store_d = 1'b1;
            state_d     = S_IDLE;
          end else if (stored_q + ONE == DEPTH) begin
            overflow_d = 1'b1;
            state_d    = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (S_AXI_TVALID && S_AXI_TLAST) begin
          fin_store_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_PRIME: begin
        rd_en    = 1'b1;
        vld_d    = 1'b1;
        last_d   = (rd_ptr_q == last_idx);
        rd_ptr_d = rd_ptr_nxt;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        if (vld_q && M_AXI_TREADY) begin
          if (last_q && passes_q == P_ONE) begin
            vld_d      = 1'b0;
            fin_load_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            if (last_q) passes_d = passes_q - P_ONE;
            rd_en    = 1'b1;
            last_d   = (rd_ptr_q == last_idx);
            rd_ptr_d = rd_ptr_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      stored_q    <= '0;
      rd_ptr_q    <= '0;
      passes_q    <= '0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      fin_store_q <= 1'b0;
      fin_load_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stored_q    <= stored_d;
      rd_ptr_q    <= rd_ptr_d;
      passes_q    <= passes_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      fin_store_q <= fin_store_d;
      fin_load_q  <= fin_load_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is not reset; the read register doubles as the output data register.
  always_ff @(posedge clk) begin
    if (wr_en) mem[stored_q[STORAGE_IDX_WIDTH-1:0]] <= {S_AXI_TKEEP, S_AXI_TDATA};
    if (rd_en) ram_rd_q <= mem[rd_ptr_q[STORAGE_IDX_WIDTH-1:0]];
  end

  assign S_AXI_TREADY = (state_q == S_STORE) || (state_q == S_DROP);
  assign M_AXI_TDATA  = ram_rd_q[DATA_WIDTH-1:0];
  assign M_AXI_TKEEP  = ram_rd_q[MW-1:DATA_WIDTH];
  assign M_AXI_TVALID = vld_q;
  assign M_AXI_TLAST  = last_q;
  assign finStore     = fin_store_q;
  assign finLoad      = fin_load_q;
  assign overflow     = overflow_q;
  assign storedBeats  = stored_q;

endmodule

// File: tb/tb_axis_capture_replay.sv
// Self-checking bench: table of capture/replay cases with a replay scoreboard, plus reset/priority sequences.
module tb_axis_capture_replay;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int RW = 8;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] S_AXI_TDATA;
  logic [KW-1:0] S_AXI_TKEEP;
  logic          S_AXI_TVALID;
  logic          S_AXI_TREADY;
  logic          S_AXI_TLAST;
  logic [DW-1:0] M_AXI_TDATA;
  logic [KW-1:0] M_AXI_TKEEP;
  logic          M_AXI_TVALID;
  logic          M_AXI_TREADY;
  logic          M_AXI_TLAST;
  logic          storeReset, loadReset, storeInit, loadInit;
  logic [RW-1:0] replayCount;
  logic          finStore, finLoad, overflow;
  logic [IW:0]   storedBeats;

  always #5 clk = ~clk;

  axis_capture_replay #(
    .DATA_WIDTH(DW), .STORAGE_IDX_WIDTH(IW), .REPLAY_CNT_WIDTH(RW)
  ) dut (
    .clk(clk), .reset(reset),
    .S_AXI_TDATA(S_AXI_TDATA), .S_AXI_TKEEP(S_AXI_TKEEP), .S_AXI_TVALID(S_AXI_TVALID),
    .S_AXI_TREADY(S_AXI_TREADY), .S_AXI_TLAST(S_AXI_TLAST),
    .M_AXI_TDATA(M_AXI_TDATA), .M_AXI_TKEEP(M_AXI_TKEEP), .M_AXI_TVALID(M_AXI_TVALID),
    .M_AXI_TREADY(M_AXI_TREADY), .M_AXI_TLAST(M_AXI_TLAST),
    .storeReset(storeReset), .loadReset(loadReset), .storeInit(storeInit), .loadInit(loadInit),
    .replayCount(replayCount), .finStore(finStore), .finLoad(finLoad), .overflow(overflow),
    .storedBeats(storedBeats)
  );

  typedef struct {
    int            n_sent;
    bit            recapture;
    logic [RW-1:0] rcnt;
    int            rdy_pct;
    int            exp_stored;
    bit            exp_ovf;
  } case_t;

  case_t             cases [6];
  logic [KW+DW:0]    sb [$];
  int                errors = 0;
  int                checks = 0;
  int                rdy_low;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [KW+DW:0] mk(input int j, input int n_sent, input int stored);
    logic [KW-1:0] k;
    logic [DW-1:0] d;
    k = (j == n_sent - 1) ? 4'h3 : 4'hF;
    d = 32'hA0 + j;
    return {k, d, (j == stored - 1)};
  endfunction

  task automatic capture(input int n);
    storeInit = 1'b1;
    tick();
    storeInit = 1'b0;
    for (int i = 0; i < n; i++) begin
      S_AXI_TVALID = 1'b1;
      S_AXI_TDATA  = 32'hA0 + i;
      S_AXI_TKEEP  = (i == n - 1) ? 4'h3 : 4'hF;
      S_AXI_TLAST  = (i == n - 1);
      if (!S_AXI_TREADY) rdy_low++;
      tick();
    end
    S_AXI_TVALID = 1'b0;
    S_AXI_TLAST  = 1'b0;
  endtask

  task automatic replay(input logic [RW-1:0] rcnt, input int pct, input int n_sent, input int stored);
    int passes, cyc, first_cyc, gaps, unstable;
    bit started, prev_stall, rdy;
    logic [KW+DW:0] prev_beat, act, exp;
    passes = (rcnt == 0) ? 1 : int'(rcnt);
    for (int p = 0; p < passes; p++)
      for (int j = 0; j < stored; j++) sb.push_back(mk(j, n_sent, stored));
    loadReset = 1'b1;
    tick();
    loadReset = 1'b0;
    chk("fin_load_cleared", finLoad, 0);
    replayCount = rcnt;
    loadInit    = 1'b1;
    tick();
    loadInit = 1'b0;
    chk("prime_no_vld", M_AXI_TVALID, 0);
    cyc = 0; first_cyc = -1; gaps = 0; unstable = 0; started = 0; prev_stall = 0; prev_beat = '0;
    while (sb.size() > 0 && cyc < 500) begin
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      M_AXI_TREADY = rdy;
      act = {M_AXI_TKEEP, M_AXI_TDATA, M_AXI_TLAST};
      if (M_AXI_TVALID) begin
        if (!started) begin
          started   = 1;
          first_cyc = cyc;
        end
        if (prev_stall && act != prev_beat) unstable++;
        if (rdy) begin
          exp = sb.pop_front();
          chk("replay_beat", act, exp);
        end
        prev_stall = !rdy;
        prev_beat  = act;
      end else begin
        if (started) gaps++;
        prev_stall = 0;
      end
      tick();
      cyc++;
    end
    M_AXI_TREADY = 1'b0;
    chk("sb_drained", sb.size(), 0);
    chk("first_vld_latency", first_cyc, 1);
    chk("no_vld_gaps", gaps, 0);
    chk("stall_stable", unstable, 0);
    chk("vld_after_done", M_AXI_TVALID, 0);
    chk("fin_load_set", finLoad, 1);
    sb.delete();
  endtask

  initial begin
    int  hs, cyc;
    bit  vld_seen;
    cases[0] = '{4,  1'b1, 8'd0, 100, 4, 1'b0};
    cases[1] = '{4,  1'b0, 8'd3, 100, 4, 1'b0};
    cases[2] = '{4,  1'b0, 8'd0, 50,  4, 1'b0};
    cases[3] = '{11, 1'b1, 8'd0, 100, 8, 1'b1};
    cases[4] = '{8,  1'b1, 8'd2, 70,  8, 1'b0};
    cases[5] = '{1,  1'b1, 8'd2, 100, 1, 1'b0};

    reset = 1'b0; S_AXI_TDATA = '0; S_AXI_TKEEP = '0; S_AXI_TVALID = 1'b0; S_AXI_TLAST = 1'b0;
    M_AXI_TREADY = 1'b0; storeReset = 1'b0; loadReset = 1'b0; storeInit = 1'b0; loadInit = 1'b0;
    replayCount = '0;
    tick();
    tick();
    chk("rst_tvalid", M_AXI_TVALID, 0);
    chk("rst_tready", S_AXI_TREADY, 0);
    chk("rst_fin_store", finStore, 0);
    chk("rst_fin_load", finLoad, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_stored", storedBeats, 0);
    reset = 1'b1;

    // loadInit with nothing stored
    loadInit = 1'b1;
    tick();
    loadInit = 1'b0;
    chk("empty_fin_load", finLoad, 1);
    vld_seen = 0;
    repeat (4) begin
      if (M_AXI_TVALID) vld_seen = 1;
      tick();
    end
    chk("empty_no_vld", vld_seen, 0);

    for (int c = 0; c < 6; c++) begin
      if (cases[c].recapture) begin
        storeReset = 1'b1;
        tick();
        storeReset = 1'b0;
        chk("store_reset_stored", storedBeats, 0);
        chk("store_reset_fin", finStore, 0);
        chk("store_reset_ovf", overflow, 0);
        rdy_low = 0;
        capture(cases[c].n_sent);
        chk("cap_tready_high", rdy_low, 0);
      end
      chk("cap_stored", storedBeats, cases[c].exp_stored);
      chk("cap_fin_store", finStore, 1);
      chk("cap_overflow", overflow, cases[c].exp_ovf);
      replay(cases[c].rcnt, cases[c].rdy_pct, cases[c].n_sent, cases[c].exp_stored);
    end

    // reset in the middle of a replay
    storeReset = 1'b1;
    tick();
    storeReset = 1'b0;
    capture(4);
    loadReset = 1'b1;
    tick();
    loadReset   = 1'b0;
    replayCount = 8'd1;
    loadInit    = 1'b1;
    tick();
    loadInit     = 1'b0;
    M_AXI_TREADY = 1'b1;
    hs = 0;
    cyc = 0;
    while (hs < 3 && cyc < 50) begin
      if (M_AXI_TVALID) hs++;
      tick();
      cyc++;
    end
    chk("mid_handshakes", hs, 3);
    chk("mid_vld_pending", M_AXI_TVALID, 1);
    reset = 1'b0;
    tick();
    reset        = 1'b1;
    M_AXI_TREADY = 1'b0;
    chk("mid_rst_tvalid", M_AXI_TVALID, 0);
    chk("mid_rst_tready", S_AXI_TREADY, 0);
    chk("mid_rst_fin_store", finStore, 0);
    chk("mid_rst_fin_load", finLoad, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_stored", storedBeats, 0);

    // storeInit wins over loadInit
    storeInit = 1'b1;
    loadInit  = 1'b1;
    tick();
    storeInit = 1'b0;
    loadInit  = 1'b0;
    chk("prio_store_entered", S_AXI_TREADY, 1);
    chk("prio_no_fin_load", finLoad, 0);
    vld_seen = 0;
    repeat (3) begin
      if (M_AXI_TVALID) vld_seen = 1;
      tick();
    end
    chk("prio_no_vld", vld_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $fatal(1);
  end

endmodule
